// File: rtl/uart_tx_hc06.sv
// uart_tx_hc06: 8N1 UART transmitter with a small byte FIFO for HC-06 replies.
module uart_tx_hc06 #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          tx_n, push, pop, bit_end, empty;

    assign tx_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign empty    = fifo_count == '0;
    assign busy     = (state != IDLE) || !empty;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = baud == BW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx_n    = tx;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                tx_n    = 1'b0;
                state_n = START;
            end
            START: if (bit_end) begin
                tx_n    = shreg[0];
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                tx_n    = (idx == 3'd7) ? 1'b1 : shreg[idx + 3'd1];
                state_n = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                // a queued byte starts its start bit right on the stop boundary
                pop     = !empty;
                tx_n    = empty;
                state_n = empty ? IDLE : START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            baud       <= '0;
            idx        <= '0;
            shreg      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            baud       <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
            idx        <= (state == DATA && bit_end) ? idx + 3'd1 : idx;
            shreg      <= pop ? mem[rd_ptr] : shreg;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            overflow   <= tx_valid && !tx_ready;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= tx_data;
endmodule

// File: tb/tb_uart_tx_hc06.sv
// tb_uart_tx_hc06: random-data bench decoding the serial line against a queue of expected bytes.
module tb_uart_tx_hc06;
    localparam int N = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx, busy, overflow;
    logic [2:0] fifo_count;

    int         n_checks = 0;
    int         n_pass = 0;
    int         gaps;
    int         peak;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       quiet;

    uart_tx_hc06 #(.CLKS_PER_BIT(N), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (int'(fifo_count) > peak) peak = int'(fifo_count);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // line level c cycles after the falling edge of a frame carrying b
    function automatic logic lvl(input logic [7:0] b, input int c);
        int k = c / N;
        return (k == 0) ? 1'b0 : (k < 9) ? b[k-1] : 1'b1;
    endfunction

    task automatic rx_frames(input int n);
        logic [7:0] e;
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (tx !== 1'b0 && w < 20*N) begin
                @(negedge clk);
                w++;
            end
            if (tx !== 1'b0) begin
                check("fall_timeout", 0, 1);
                return;
            end
            if (i > 0) gaps += w;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 0, 1);
                return;
            end
            e = exp_q.pop_front();
            for (int c = 0; c < 10*N; c++) begin
                check("line", tx, lvl(e, c));
                if (c == 10*N - 1) check("busy_in_stop", busy, 1);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        #3 reset = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // single byte: one-cycle latency and full frame
        d = 8'($urandom);
        exp_q.push_back(d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("lat_idle", tx, 1);
        check("lat_count", fifo_count, 1);
        @(negedge clk);
        check("lat_fall", tx, 0);
        rx_frames(1);
        check("single_busy_done", busy, 0);

        // back-to-back bursts of four
        for (int r = 0; r < 3; r++) begin
            peak = 0;
            gaps = 0;
            fork
                begin
                    for (int k = 0; k < 4; k++) begin
                        d = 8'($urandom);
                        exp_q.push_back(d);
                        tx_data = d;
                        tx_valid = 1'b1;
                        @(negedge clk);
                    end
                    tx_valid = 1'b0;
                end
                rx_frames(4);
            join
            check("b2b_peak", peak, 3);
            check("b2b_gaps", gaps, 0);
            check("b2b_busy", busy, 0);
            check("b2b_left", exp_q.size(), 0);
        end

        // overflow: sixth consecutive request is dropped
        peak = 0;
        gaps = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    d = 8'($urandom);
                    if (k < 5) exp_q.push_back(d);
                    tx_data = d;
                    tx_valid = 1'b1;
                    check("ovf_ready", tx_ready, k < 5);
                    check("ovf_low", overflow, 0);
                    @(negedge clk);
                end
                tx_valid = 1'b0;
                check("ovf_pulse", overflow, 1);
                check("ovf_full", fifo_count, 4);
                @(negedge clk);
                check("ovf_clear", overflow, 0);
            end
            rx_frames(5);
        join
        check("ovf_gaps", gaps, 0);
        check("ovf_peak", peak, 4);
        check("ovf_left", exp_q.size(), 0);
        check("ovf_busy", busy, 0);

        // reset during data bit 3 with two bytes queued
        for (int k = 0; k < 3; k++) begin
            tx_data = 8'($urandom);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("mid_queued", fifo_count, 2);
        repeat (4*N + 1) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_tx", tx, 1);
        check("mid_count", fifo_count, 0);
        check("mid_busy", busy, 0);
        check("mid_ready", tx_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (20*N) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet = 1'b0;
        end
        check("mid_quiet", quiet, 1);
        check("mid_idle_busy", busy, 0);

        // pointer wrap: ten bytes paced on tx_ready
        peak = 0;
        gaps = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int w = 0;
                    while (!tx_ready && w < 1000) begin
                        @(negedge clk);
                        w++;
                    end
                    d = 8'h30 + 8'(i);
                    exp_q.push_back(d);
                    tx_data = d;
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
            rx_frames(10);
        join
        check("wrap_peak", peak, 4);
        check("wrap_gaps", gaps, 0);
        check("wrap_left", exp_q.size(), 0);
        check("wrap_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
